// File: rtl/fpmul_pkg.sv
// Shared types and constants for the pipelined binary32 multiplier.
// Holds the format widths, rounding-mode and operand-class enums,
// the packed per-stage payload structs and two small decode helpers.
package fpmul_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned E_W    = 10;
  localparam int unsigned BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fclass_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // S1 -> S2 payload: special-case result resolved early, raw product otherwise
  typedef struct packed {
    logic                   special;
    logic [31:0]            spec_z;
    logic                   sign;
    rmode_e                 mode;
    logic signed [E_W-1:0]  exp;
    logic [PROD_W-1:0]      prod;
  } s1_t;

  // S2 -> S3 payload: normalized significand with guard/round/sticky
  typedef struct packed {
    logic                   special;
    logic [31:0]            spec_z;
    logic                   sign;
    rmode_e                 mode;
    logic signed [E_W-1:0]  exp;
    logic [SIG_W-1:0]       man;
    logic                   g;
    logic                   r;
    logic                   s;
  } s2_t;

  // Unused mode codes fall back to round-to-nearest-even
  function automatic rmode_e decode_rmode(input logic [2:0] code);
    if (code > 3'd4) return RM_RNE;
    return rmode_e'(code);
  endfunction

  // Subnormals classify as zero (flush on input)
  function automatic fclass_e classify(input fp32_t f);
    if (f.exp == '0) return ZERO;
    if (f.exp == '1) return (f.man != '0) ? NAN : INF;
    return NORM;
  endfunction

endpackage

// File: rtl/fpmul_round.sv
// Combinational rounding/packing for the final multiplier stage.
// Ports: sign, man (24-bit normalized significand), g/r/s, exp (unbounded
// signed exponent), mode -> z_c (packed binary32), ovrf_c, udrf_c.
module fpmul_round
  import fpmul_pkg::*;
(
  input  logic                  sign,
  input  logic [SIG_W-1:0]      man,
  input  logic                  g,
  input  logic                  r,
  input  logic                  s,
  input  logic signed [E_W-1:0] exp,
  input  rmode_e                mode,
  output logic [31:0]           z_c,
  output logic                  ovrf_c,
  output logic                  udrf_c
);

  localparam logic signed [E_W-1:0] EXP_OVF  = E_W'(255);
  localparam logic signed [E_W-1:0] EXP_ZERO = '0;

  logic                  inc;
  logic [SIG_W:0]        sum;
  logic [MAN_W-1:0]      frac_r;
  logic signed [E_W-1:0] exp_r;
  logic [31:0]           inf_z;
  logic [31:0]           max_z;

  // Round increment, carry renormalization, then range check and pack
  always_comb begin
    inc    = 1'b0;
    sum    = '0;
    frac_r = '0;
    exp_r  = exp;
    inf_z  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    max_z  = {sign, MAX_FIN[30:0]};
    z_c    = '0;
    ovrf_c = 1'b0;
    udrf_c = 1'b0;

    case (mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = ~sign & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = g & (r | s | man[0]);
    endcase

    sum = {1'b0, man} + (SIG_W + 1)'(inc);
    // Carry out means the significand was all ones; result is 1.0 * 2^(e+1)
    if (sum[SIG_W]) begin
      frac_r = sum[MAN_W:1];
      exp_r  = exp + E_W'(1);
    end else begin
      frac_r = sum[MAN_W-1:0];
    end

    ovrf_c = (exp_r >= EXP_OVF);
    udrf_c = (exp_r <= EXP_ZERO);

    if (ovrf_c) begin
      case (mode)
        RM_RTZ:  z_c = max_z;
        RM_RDN:  z_c = sign ? inf_z : max_z;
        RM_RUP:  z_c = sign ? max_z : inf_z;
        default: z_c = inf_z;
      endcase
    end else if (udrf_c) begin
      z_c = {sign, 31'h0};
    end else begin
      z_c = {sign, exp_r[EXP_W-1:0], frac_r};
    end
  end

endmodule

// File: rtl/fpmul_pipe.sv
// Pipelined binary32 multiplier, one operand pair per cycle, fixed latency.
// Ports: clk, rst (sync, active high), in_valid, r_mode[2:0], fp_X, fp_Y ->
// out_valid, fp_Z, ovrf, udrf. Operands sampled at edge N leave on edge N+3:
// an input capture register, S1 (classify/exp sum/multiply), S2
// (normalize/GRS), and the S3 rounding logic feeding the output flops.
module fpmul_pipe
  import fpmul_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  r_mode,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  output logic        out_valid,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  localparam int unsigned GRS_LSB = PROD_W - SIG_W;

  logic [LATENCY-1:0] valid_sr;
  fp32_t              x_q;
  fp32_t              y_q;
  logic [2:0]         mode_q;
  s1_t                s1_d;
  s1_t                s1_q;
  s2_t                s2_d;
  s2_t                s2_q;
  fclass_e            cx;
  fclass_e            cy;
  logic [31:0]        rnd_z_c;
  logic               rnd_ovrf_c;
  logic               rnd_udrf_c;

  // Stage valids; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr  <= '0;
      out_valid <= 1'b0;
    end else begin
      valid_sr  <= {valid_sr[LATENCY-2:0], in_valid};
      out_valid <= valid_sr[LATENCY-1];
    end
  end

  // Datapath registers, loaded only when their stage carries a valid op
  always_ff @(posedge clk) begin
    if (in_valid) begin
      x_q    <= fp_X;
      y_q    <= fp_Y;
      mode_q <= r_mode;
    end
    if (valid_sr[0]) s1_q <= s1_d;
    if (valid_sr[1]) s2_q <= s2_d;
  end

  // S1: classify, resolve special cases, exponent sum, significand product
  always_comb begin
    s1_d         = '0;
    cx           = classify(x_q);
    cy           = classify(y_q);
    s1_d.sign    = x_q.sign ^ y_q.sign;
    s1_d.mode    = decode_rmode(mode_q);
    s1_d.exp     = E_W'(x_q.exp) + E_W'(y_q.exp) - E_W'(BIAS);
    s1_d.prod    = PROD_W'({1'b1, x_q.man}) * PROD_W'({1'b1, y_q.man});
    s1_d.special = 1'b1;
    if (cx == NAN || cy == NAN || (cx == INF && cy == ZERO) || (cx == ZERO && cy == INF)) begin
      s1_d.spec_z = QNAN;
    end else if (cx == INF || cy == INF) begin
      s1_d.spec_z = {s1_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cx == ZERO || cy == ZERO) begin
      s1_d.spec_z = {s1_d.sign, 31'h0};
    end else begin
      s1_d.special = 1'b0;
    end
  end

  // S2: normalize to 1.x and extract guard/round/sticky
  always_comb begin
    s2_d         = '0;
    s2_d.special = s1_q.special;
    s2_d.spec_z  = s1_q.spec_z;
    s2_d.sign    = s1_q.sign;
    s2_d.mode    = s1_q.mode;
    if (s1_q.prod[PROD_W-1]) begin
      s2_d.man = s1_q.prod[PROD_W-1 -: SIG_W];
      s2_d.g   = s1_q.prod[GRS_LSB-1];
      s2_d.r   = s1_q.prod[GRS_LSB-2];
      s2_d.s   = |s1_q.prod[GRS_LSB-3:0];
      s2_d.exp = s1_q.exp + E_W'(1);
    end else begin
      s2_d.man = s1_q.prod[PROD_W-2 -: SIG_W];
      s2_d.g   = s1_q.prod[GRS_LSB-2];
      s2_d.r   = s1_q.prod[GRS_LSB-3];
      s2_d.s   = |s1_q.prod[GRS_LSB-4:0];
      s2_d.exp = s1_q.exp;
    end
  end

  // S3: rounding and packing
  fpmul_round u_round (
    .sign   (s2_q.sign),
    .man    (s2_q.man),
    .g      (s2_q.g),
    .r      (s2_q.r),
    .s      (s2_q.s),
    .exp    (s2_q.exp),
    .mode   (s2_q.mode),
    .z_c    (rnd_z_c),
    .ovrf_c (rnd_ovrf_c),
    .udrf_c (rnd_udrf_c)
  );

  // Result registers hold their value between valid results
  always_ff @(posedge clk) begin
    if (rst) begin
      fp_Z <= '0;
      ovrf <= 1'b0;
      udrf <= 1'b0;
    end else if (valid_sr[LATENCY-1]) begin
      if (s2_q.special) begin
        fp_Z <= s2_q.spec_z;
        ovrf <= 1'b0;
        udrf <= 1'b0;
      end else begin
        fp_Z <= rnd_z_c;
        ovrf <= rnd_ovrf_c;
        udrf <= rnd_udrf_c;
      end
    end
  end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Self-checking bench for fpmul_pipe: directed corner vectors with known
// results, then randomized traffic with bubbles and occasional resets,
// compared every cycle against an arithmetic reference model.
module tb_fpmul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  r_mode;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic        out_valid;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;

  fpmul_pipe #(.LATENCY(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .r_mode    (r_mode),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .out_valid (out_valid),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] z;
    logic        ov;
    logic        ud;
    logic        hw;
    logic [31:0] wz;
    logic        wov;
    logic        wud;
  } ent_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  m;
    logic [31:0] z;
    logic        ov;
    logic        ud;
  } dir_t;

  int          n_chk = 0;
  int          n_fail = 0;
  ent_t        pipe [4];
  logic [31:0] hz = '0;
  logic        hov = 1'b0;
  logic        hud = 1'b0;
  dir_t        dirs [24];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded
  // remainder with half an ulp
  function automatic ent_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    ent_t            res;
    longint unsigned p, q, rem, half;
    int              ex, ey, k, e, mode;
    bit              sg, xz, yz, xi, yi, xn, yn, up;
    res  = '0;
    res.v = 1'b1;
    ex   = int'(x[30:23]);
    ey   = int'(y[30:23]);
    sg   = x[31] ^ y[31];
    xz   = (ex == 0);
    yz   = (ey == 0);
    xi   = (ex == 255) && (x[22:0] == 0);
    yi   = (ey == 255) && (y[22:0] == 0);
    xn   = (ex == 255) && (x[22:0] != 0);
    yn   = (ey == 255) && (y[22:0] != 0);
    mode = (m > 3'd4) ? 0 : int'(m);
    if (xn || yn || (xi && yz) || (yi && xz)) begin
      res.z = 32'h7FC0_0000;
    end else if (xi || yi) begin
      res.z = {sg, 8'hFF, 23'h0};
    end else if (xz || yz) begin
      res.z = {sg, 31'h0};
    end else begin
      p    = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
      k    = (p >= (64'd1 << 47)) ? 24 : 23;
      e    = ex + ey - 127 + (k - 23);
      q    = p >> k;
      rem  = p - (q << k);
      half = 64'd1 << (k - 1);
      case (mode)
        0:       up = (rem > half) || ((rem == half) && q[0]);
        1:       up = 1'b0;
        2:       up = sg && (rem != 0);
        3:       up = !sg && (rem != 0);
        default: up = (rem >= half);
      endcase
      q = q + 64'(up);
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        res.ov = 1'b1;
        case (mode)
          1:       res.z = sg ? 32'hFF7F_FFFF : 32'h7F7F_FFFF;
          2:       res.z = sg ? 32'hFF80_0000 : 32'h7F7F_FFFF;
          3:       res.z = sg ? 32'hFF7F_FFFF : 32'h7F80_0000;
          default: res.z = sg ? 32'hFF80_0000 : 32'h7F80_0000;
        endcase
      end else if (e <= 0) begin
        res.ud = 1'b1;
        res.z  = {sg, 31'h0};
      end else begin
        res.z = {sg, 8'(e), 23'(q)};
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 11))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(1, 70));
      4, 5:    e = 8'($urandom_range(180, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    f = 23'($urandom);
    case ($urandom_range(0, 5))
      0:       f = '1;
      1:       f = f & 23'h7F_F000;
      2:       f = '0;
      default: ;
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One clock: drive, advance the model, then compare after the edge
  task automatic step(input logic v, input logic r, input logic [31:0] x, input logic [31:0] y,
                      input logic [2:0] m, input logic hw, input logic [31:0] wz,
                      input logic wov, input logic wud);
    rst      = r;
    in_valid = v;
    fp_X     = x;
    fp_Y     = y;
    r_mode   = m;
    @(posedge clk);
    for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = '0;
    if (v && !r) begin
      pipe[0]     = model(x, y, m);
      pipe[0].hw  = hw;
      pipe[0].wz  = wz;
      pipe[0].wov = wov;
      pipe[0].wud = wud;
    end
    if (r) begin
      for (int i = 0; i < 4; i++) pipe[i] = '0;
      hz  = '0;
      hov = 1'b0;
      hud = 1'b0;
    end else if (pipe[3].v) begin
      hz  = pipe[3].z;
      hov = pipe[3].ov;
      hud = pipe[3].ud;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(pipe[3].v));
    check("fp_Z", fp_Z, hz);
    check("ovrf", 32'(ovrf), 32'(hov));
    check("udrf", 32'(udrf), 32'(hud));
    if (pipe[3].v && pipe[3].hw) begin
      check("dir_fp_Z", fp_Z, pipe[3].wz);
      check("dir_flags", {30'h0, ovrf, udrf}, {30'h0, pipe[3].wov, pipe[3].wud});
    end
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, r, '0, '0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_dir(input int i);
    step(1'b1, 1'b0, dirs[i].x, dirs[i].y, dirs[i].m, 1'b1, dirs[i].z, dirs[i].ov, dirs[i].ud);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    dirs[0]  = '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0};
    dirs[1]  = '{32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 1'b1, 1'b0};
    dirs[2]  = '{32'h7F000000, 32'h40000000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0};
    dirs[3]  = '{32'hFF000000, 32'h40000000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0};
    dirs[4]  = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 1'b0, 1'b1};
    dirs[5]  = '{32'h80800000, 32'h3F000000, 3'd0, 32'h80000000, 1'b0, 1'b1};
    dirs[6]  = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0};
    dirs[7]  = '{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 1'b0, 1'b0};
    dirs[8]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 1'b0, 1'b0};
    dirs[9]  = '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 1'b0, 1'b0};
    dirs[10] = '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 1'b0, 1'b0};
    dirs[11] = '{32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 1'b0, 1'b0};
    dirs[12] = '{32'hFF000000, 32'h40000000, 3'd2, 32'hFF800000, 1'b1, 1'b0};
    dirs[13] = '{32'h7F000000, 32'h40000000, 3'd5, 32'h7F800000, 1'b1, 1'b0};
    dirs[14] = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 1'b0, 1'b0};
    dirs[15] = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 1'b0, 1'b0};
    dirs[16] = '{32'h3FB504F3, 32'h3FB504F3, 3'd3, 32'h40000000, 1'b0, 1'b0};
    dirs[17] = '{32'h3FB504F3, 32'h3FB504F3, 3'd1, 32'h3FFFFFFF, 1'b0, 1'b0};
    dirs[18] = '{32'h3F7FFFFF, 32'h00800001, 3'd0, 32'h00800000, 1'b0, 1'b0};
    dirs[19] = '{32'h3F3504F3, 32'h00B504F3, 3'd3, 32'h00800000, 1'b0, 1'b0};
    dirs[20] = '{32'h3F3504F3, 32'h00B504F3, 3'd1, 32'h00000000, 1'b0, 1'b1};
    dirs[21] = '{32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 1'b0, 1'b0};
    dirs[22] = '{32'h00000000, 32'hC0000000, 3'd0, 32'h80000000, 1'b0, 1'b0};
    dirs[23] = '{32'h007FFFFF, 32'h3F800000, 3'd0, 32'h00000000, 1'b0, 1'b0};

    // Reset state
    idle(3, 1'b1);
    idle(2, 1'b0);

    // Single pulse, then drain
    run_dir(0);
    idle(4, 1'b0);

    // Directed stream with a bubble after the second op
    for (int i = 0; i < 24; i++) begin
      run_dir(i);
      if (i == 1) idle(1, 1'b0);
    end
    idle(4, 1'b0);

    // Reset with three ops in flight: none may emerge, outputs clear
    for (int i = 0; i < 3; i++) run_dir(i + 1);
    idle(1, 1'b1);
    idle(5, 1'b0);

    // Randomized traffic: bubbles, mode changes every cycle, rare resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 6) != 0), 1'($urandom_range(0, 299) == 0),
           rnd_fp(), rnd_fp(), 3'($urandom_range(0, 7)), 1'b0, '0, 1'b0, 1'b0);
    end
    idle(4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
